// File: rtl/status_branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : status_branch_ctrl_pkg
// Description : Shared encodings for the status register / branch resolver.
// Revision    : 1.0 - initial release
// ============================================================================
package status_branch_ctrl_pkg;

    localparam logic [2:0] c_br_none = 3'b000;
    localparam logic [2:0] c_br_bz   = 3'b001;
    localparam logic [2:0] c_br_bnz  = 3'b010;
    localparam logic [2:0] c_br_bn   = 3'b011;
    localparam logic [2:0] c_br_bv   = 3'b100;
    localparam logic [2:0] c_br_j    = 3'b101;
    localparam logic [2:0] c_br_jr   = 3'b110;
    localparam logic [2:0] c_br_jal  = 3'b111;

    localparam int c_bit_zero = 2;
    localparam int c_bit_neg  = 1;
    localparam int c_bit_ovf  = 0;

    // Destination register of the link write issued by jal
    localparam logic [4:0] c_link_reg = 5'd31;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_VECTOR   = 2'd2
    } state_t;

    function automatic logic br_cond(input logic [2:0] sel, input logic [2:0] f);
        logic r;
        r = 1'b0;
        case (sel)
            c_br_bz:                     r = f[c_bit_zero];
            c_br_bnz:                    r = ~f[c_bit_zero];
            c_br_bn:                     r = f[c_bit_neg];
            c_br_bv:                     r = f[c_bit_ovf];
            c_br_j, c_br_jr, c_br_jal:   r = 1'b1;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_branch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : status_branch_ctrl_if
// Description : ALU-status / branch / trap bundle between datapath and resolver.
// Revision    : 1.0 - initial release
// ============================================================================
interface status_branch_ctrl_if;
    logic        stswrite;
    logic [2:0]  status_in;
    logic [2:0]  br_sel;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [25:0] jtarget;
    logic [31:0] rs_val;
    logic        exc_ack;
    logic [31:0] next_pc;
    logic        take;
    logic        link_we;
    logic [31:0] link_data;
    logic [2:0]  status_q;
    logic        ovf_sticky;
    logic        exc_req;
    logic [31:0] epc;
    logic        stall;

    modport master (
        output stswrite, status_in, br_sel, pc, imm, jtarget, rs_val, exc_ack,
        input  next_pc, take, link_we, link_data, status_q, ovf_sticky,
               exc_req, epc, stall
    );

    modport slave (
        input  stswrite, status_in, br_sel, pc, imm, jtarget, rs_val, exc_ack,
        output next_pc, take, link_we, link_data, status_q, ovf_sticky,
               exc_req, epc, stall
    );
endinterface
`default_nettype wire

// File: rtl/status_branch_ctrl_branch_target_gen.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_gen
// Description : Combinational pc+4, relative branch and pseudo-direct jump targets.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_gen (
    input  wire logic [31:0] pc,
    input  wire logic [31:0] imm,
    input  wire logic [25:0] jtarget,
    output logic      [31:0] pc_plus4,
    output logic      [31:0] br_target,
    output logic      [31:0] j_target
);
    logic [31:0] w_imm_bytes;

    assign w_imm_bytes = imm << 2;
    assign pc_plus4    = pc + 32'd4;
    // Wrap-around past 2^32 is intentional and silent
    assign br_target   = pc_plus4 + w_imm_bytes;
    assign j_target    = {pc_plus4[31:28], jtarget, 2'b00};
endmodule
`default_nettype wire

// File: rtl/status_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : status_branch_ctrl
// Description : Status register, branch/jump resolution and overflow trap FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module status_branch_ctrl
    import status_branch_ctrl_pkg::*;
#(
    parameter bit          TRAP_EN    = 1'b1,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter bit          BYPASS     = 1'b0
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    status_branch_ctrl_if.slave bus
);
    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_status;
    logic        r_ovf_sticky;
    logic [31:0] r_epc;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_run_target;
    logic [2:0]  w_flags;
    logic        w_cond;
    logic        w_sts_we;
    logic        w_trap;
    logic [31:0] w_next_pc;
    logic        w_take;
    logic        w_link_we;
    logic        w_exc_req;
    logic        w_stall;

    branch_target_gen u_tgt (
        .pc        (bus.pc),
        .imm       (bus.imm),
        .jtarget   (bus.jtarget),
        .pc_plus4  (w_pc_plus4),
        .br_target (w_br_target),
        .j_target  (w_j_target)
    );

    assign w_flags  = (BYPASS && bus.stswrite) ? bus.status_in : r_status;
    assign w_cond   = br_cond(bus.br_sel, w_flags);
    assign w_sts_we = bus.stswrite && (r_state == ST_RUN);
    assign w_trap   = TRAP_EN && w_sts_we && bus.status_in[c_bit_ovf];

    always_comb begin
        w_run_target = w_br_target;
        case (bus.br_sel)
            c_br_j, c_br_jal: w_run_target = w_j_target;
            c_br_jr:          w_run_target = bus.rs_val;
            default:          w_run_target = w_br_target;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_status     <= 3'b000;
            r_ovf_sticky <= 1'b0;
            r_epc        <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sts_we) begin
                r_status <= bus.status_in;
                if (bus.status_in[c_bit_ovf]) begin
                    r_ovf_sticky <= 1'b1;
                end
            end
            if (w_trap) begin
                r_epc <= bus.pc;
            end
        end
    end

    // The branch in the overflowing cycle still resolves; the trap starts next cycle
    always_comb begin
        w_state_nxt = r_state;
        w_next_pc   = w_pc_plus4;
        w_take      = 1'b0;
        w_link_we   = 1'b0;
        w_exc_req   = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_take    = w_cond;
                w_link_we = (bus.br_sel == c_br_jal);
                if (w_cond) begin
                    w_next_pc = w_run_target;
                end
                if (w_trap) begin
                    w_state_nxt = ST_EXC_WAIT;
                end
            end
            ST_EXC_WAIT: begin
                w_exc_req = 1'b1;
                w_stall   = 1'b1;
                w_next_pc = bus.pc;
                if (bus.exc_ack) begin
                    w_state_nxt = ST_VECTOR;
                end
            end
            ST_VECTOR: begin
                w_next_pc   = EXC_VECTOR;
                w_take      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.next_pc    = w_next_pc;
    assign bus.take       = w_take;
    assign bus.link_we    = w_link_we;
    assign bus.link_data  = w_pc_plus4;
    assign bus.status_q   = r_status;
    assign bus.ovf_sticky = r_ovf_sticky;
    assign bus.exc_req    = w_exc_req;
    assign bus.epc        = r_epc;
    assign bus.stall      = w_stall;
endmodule
`default_nettype wire

// File: tb/tb_status_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_branch_ctrl
// Description : Directed bench for status_branch_ctrl, BYPASS=0 and BYPASS=1 copies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_branch_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    status_branch_ctrl_if if0 ();
    status_branch_ctrl_if if1 ();

    status_branch_ctrl #(.TRAP_EN(1'b1), .EXC_VECTOR(32'h0000_0080), .BYPASS(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    status_branch_ctrl #(.TRAP_EN(1'b1), .EXC_VECTOR(32'h0000_0080), .BYPASS(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic sw, input logic [2:0] st, input logic [2:0] sel,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [25:0] jt, input logic [31:0] rs, input logic ack);
        if0.stswrite = sw;  if1.stswrite = sw;
        if0.status_in = st; if1.status_in = st;
        if0.br_sel = sel;   if1.br_sel = sel;
        if0.pc = pc;        if1.pc = pc;
        if0.imm = imm;      if1.imm = imm;
        if0.jtarget = jt;   if1.jtarget = jt;
        if0.rs_val = rs;    if1.rs_val = rs;
        if0.exc_ack = ack;  if1.exc_ack = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        set_in(1'b0, 3'b000, 3'b000, 32'h100, 32'd0, 26'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_status_q",   {29'd0, if0.status_q}, 32'd0);
        chk("rst_ovf_sticky", {31'd0, if0.ovf_sticky}, 32'd0);
        chk("rst_epc",        if0.epc, 32'd0);
        chk("rst_exc_req",    {31'd0, if0.exc_req}, 32'd0);
        chk("rst_stall",      {31'd0, if0.stall}, 32'd0);
        chk("rst_next_pc",    if0.next_pc, 32'h104);
        chk("rst_take",       {31'd0, if0.take}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero flag written, then bz / bnz the next cycle
        step();
        set_in(1'b1, 3'b100, 3'b000, 32'h100, 32'd0, 26'd0, 32'd0, 1'b0);
        step();
        set_in(1'b0, 3'b000, 3'b001, 32'h100, 32'd3, 26'd0, 32'd0, 1'b0);
        #1;
        chk("bz_status_q", {29'd0, if0.status_q}, 32'h4);
        chk("bz_take",     {31'd0, if0.take}, 32'd1);
        chk("bz_next_pc",  if0.next_pc, 32'h110);
        set_in(1'b0, 3'b000, 3'b010, 32'h100, 32'd3, 26'd0, 32'd0, 1'b0);
        #1;
        chk("bnz_take",    {31'd0, if0.take}, 32'd0);
        chk("bnz_next_pc", if0.next_pc, 32'h104);

        // Same-cycle write + bn: only the bypassing copy sees it
        step();
        set_in(1'b1, 3'b000, 3'b000, 32'h300, 32'd0, 26'd0, 32'd0, 1'b0);
        step();
        set_in(1'b1, 3'b010, 3'b011, 32'h300, 32'd2, 26'd0, 32'd0, 1'b0);
        #1;
        chk("nobyp_status_q", {29'd0, if0.status_q}, 32'd0);
        chk("nobyp_take",     {31'd0, if0.take}, 32'd0);
        chk("nobyp_next_pc",  if0.next_pc, 32'h304);
        chk("byp_take",       {31'd0, if1.take}, 32'd1);
        chk("byp_next_pc",    if1.next_pc, 32'h30C);
        step();
        set_in(1'b0, 3'b000, 3'b011, 32'h300, 32'd2, 26'd0, 32'd0, 1'b0);
        #1;
        chk("bn_late_status_q", {29'd0, if0.status_q}, 32'h2);
        chk("bn_late_take",     {31'd0, if0.take}, 32'd1);

        // jal / jr / j
        set_in(1'b0, 3'b000, 3'b111, 32'h0040_0000, 32'd0, 26'h10, 32'd0, 1'b0);
        #1;
        chk("jal_next_pc",   if0.next_pc, 32'h0000_0040);
        chk("jal_take",      {31'd0, if0.take}, 32'd1);
        chk("jal_link_we",   {31'd0, if0.link_we}, 32'd1);
        chk("jal_link_data", if0.link_data, 32'h0040_0004);
        set_in(1'b0, 3'b000, 3'b110, 32'h0040_0000, 32'd0, 26'h10, 32'hFFFF_FFFC, 1'b0);
        #1;
        chk("jr_next_pc", if0.next_pc, 32'hFFFF_FFFC);
        chk("jr_link_we", {31'd0, if0.link_we}, 32'd0);
        set_in(1'b0, 3'b000, 3'b101, 32'hF000_0000, 32'd0, 26'h3FF_FFFF, 32'd0, 1'b0);
        #1;
        chk("j_next_pc", if0.next_pc, 32'hFFFF_FFFC);

        // Overflow write at pc=0x200 raises the trap from the next cycle
        step();
        set_in(1'b1, 3'b001, 3'b000, 32'h200, 32'd0, 26'd0, 32'd0, 1'b0);
        #1;
        chk("trap_edge_exc_req", {31'd0, if0.exc_req}, 32'd0);
        step();
        set_in(1'b1, 3'b100, 3'b001, 32'h204, 32'd5, 26'd0, 32'd0, 1'b0);
        #1;
        chk("wait_exc_req", {31'd0, if0.exc_req}, 32'd1);
        chk("wait_stall",   {31'd0, if0.stall}, 32'd1);
        chk("wait_epc",     if0.epc, 32'h200);
        chk("wait_take",    {31'd0, if0.take}, 32'd0);
        chk("wait_next_pc", if0.next_pc, 32'h204);
        chk("wait_sticky",  {31'd0, if0.ovf_sticky}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_exc_req",  {31'd0, if0.exc_req}, 32'd1);
            chk("hold_status_q", {29'd0, if0.status_q}, 32'h1);
        end
        set_in(1'b0, 3'b000, 3'b000, 32'h204, 32'd0, 26'd0, 32'd0, 1'b1);
        step();
        set_in(1'b0, 3'b000, 3'b000, 32'h204, 32'd0, 26'd0, 32'd0, 1'b0);
        #1;
        chk("vec_next_pc", if0.next_pc, 32'h80);
        chk("vec_take",    {31'd0, if0.take}, 32'd1);
        chk("vec_stall",   {31'd0, if0.stall}, 32'd0);
        chk("vec_exc_req", {31'd0, if0.exc_req}, 32'd0);
        step();
        chk("run_next_pc",  if0.next_pc, 32'h208);
        chk("run_take",     {31'd0, if0.take}, 32'd0);
        chk("run_sticky",   {31'd0, if0.ovf_sticky}, 32'd1);
        chk("run_status_q", {29'd0, if0.status_q}, 32'h1);

        // bv with status_q[0]=1 and wrap past 2^32
        set_in(1'b0, 3'b000, 3'b100, 32'hFFFF_FFF8, 32'd1, 26'd0, 32'd0, 1'b0);
        #1;
        chk("wrap_next_pc", if0.next_pc, 32'h0000_0000);
        chk("wrap_take",    {31'd0, if0.take}, 32'd1);

        // exc_ack in RUN does nothing
        set_in(1'b0, 3'b000, 3'b000, 32'h10, 32'd0, 26'd0, 32'd0, 1'b1);
        step();
        set_in(1'b0, 3'b000, 3'b000, 32'h10, 32'd0, 26'd0, 32'd0, 1'b0);
        #1;
        chk("stray_ack_stall",   {31'd0, if0.stall}, 32'd0);
        chk("stray_ack_next_pc", if0.next_pc, 32'h14);

        // Asynchronous reset in the middle of EXC_WAIT
        set_in(1'b1, 3'b001, 3'b000, 32'h400, 32'd0, 26'd0, 32'd0, 1'b0);
        step();
        set_in(1'b0, 3'b000, 3'b000, 32'h400, 32'd0, 26'd0, 32'd0, 1'b0);
        #1;
        chk("pre_rst_exc_req", {31'd0, if0.exc_req}, 32'd1);
        chk("pre_rst_epc",     if0.epc, 32'h400);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_exc_req",  {31'd0, if0.exc_req}, 32'd0);
        chk("mid_rst_stall",    {31'd0, if0.stall}, 32'd0);
        chk("mid_rst_status_q", {29'd0, if0.status_q}, 32'd0);
        chk("mid_rst_sticky",   {31'd0, if0.ovf_sticky}, 32'd0);
        chk("mid_rst_epc",      if0.epc, 32'd0);
        chk("mid_rst_next_pc",  if0.next_pc, 32'h404);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/status_branch_ctrl.md
Name: status_branch_ctrl

Overview:
- Consumer end of the ALU status interface (status bit 2 = zero, bit 1 = negative, bit 0 = overflow).
- Holds the architectural status register, written when stswrite is high.
- Resolves status-conditioned branches and jumps into the next PC, and produces link writes.
- Raises a handshaked overflow trap toward the control unit.
- Sits between the ALU and the PC register in the datapath.

Parameters:
TRAP_EN, 1, 1 = overflow on a status write raises a trap; 0 = overflow only sets the sticky flag
EXC_VECTOR, 32'h0000_0080, PC loaded after a trap is acknowledged
BYPASS, 0, 1 = branch evaluation uses status_in when stswrite is high in the same cycle

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stswrite  input  1  capture status_in at this edge
status_in  input  3  ALU flags {zero, negative, overflow}
br_sel  input  3  000 none, 001 bz, 010 bnz, 011 bn, 100 bv, 101 j, 110 jr, 111 jal
pc  input  32  address of the current instruction
imm  input  32  sign-extended branch offset, in words
jtarget  input  26  jump index field
rs_val  input  32  register target for jr
exc_ack  input  1  control unit accepts the trap
next_pc  output  32  PC value for the next edge
take  output  1  branch or jump taken this cycle
link_we  output  1  write link_data to $31
link_data  output  32  pc+4
status_q  output  3  registered status
ovf_sticky  output  1  sticky overflow flag
exc_req  output  1  trap request
epc  output  32  pc of the overflowing instruction
stall  output  1  freeze PC and register writes

Behaviour:
- Reset (asynchronous, rst_n low): status_q=0, ovf_sticky=0, epc=0, state=RUN, exc_req=0, stall=0.
  - Next-PC logic stays combinational during reset.
  - Reset mid-trap aborts the trap and returns to RUN.
- Status register: on each rising edge with stswrite=1 and state=RUN, status_q <= status_in. Writes are ignored in EXC_WAIT and VECTOR.
- Sticky overflow: ovf_sticky <= 1 on any accepted write with status_in[0]=1. Cleared only by reset.
- Flag source for evaluation (f):
  - f = status_q by default.
  - If BYPASS=1 and stswrite=1, f = status_in.
- Conditions, evaluated combinationally:
  - bz: f[2]=1.
  - bnz: f[2]=0.
  - bn: f[1]=1.
  - bv: f[0]=1.
  - j, jr, jal: always taken.
  - none: never taken.
- Targets (all arithmetic is 32-bit modulo 2^32; wrap-around is silent):
  - branches: pc+4+(imm<<2).
  - j and jal: {pc_plus4[31:28], jtarget, 2'b00}.
  - jr: rs_val, unmodified, with no alignment check.
- Outputs in RUN:
  - take=1 when the condition holds; next_pc = target if taken, else pc+4.
  - link_we=1 only for jal.
  - link_data = pc+4 at all times.
- FSM states: RUN, EXC_WAIT, VECTOR.
  - RUN -> EXC_WAIT: at an edge where TRAP_EN=1, stswrite=1 and status_in[0]=1. At that edge epc <= pc.
  - EXC_WAIT: exc_req=1, stall=1, take=0, link_we=0, next_pc=pc.
  - EXC_WAIT -> VECTOR: on exc_ack=1. exc_req deasserts the cycle after ack is sampled.
  - VECTOR (one cycle): next_pc=EXC_VECTOR, take=1, stall=0, link_we=0.
  - VECTOR -> RUN unconditionally.
- A branch in the same cycle as the overflowing write still resolves normally in that cycle; the trap takes effect from the next cycle.
- exc_ack outside EXC_WAIT is ignored.
- Latency:
  - With BYPASS=0, a flag written at edge N is visible to branches from cycle N+1.
  - With BYPASS=1, it is visible in the same cycle.

Decomposition:
- Shared package holds:
  - br_sel encodings.
  - Status bit indices (ZERO=2, NEG=1, OVF=0).
  - FSM state typedef.
  - The link register number, 31.
- One sub-module, branch_target_gen: purely combinational pc+4, branch and jump target generation. This block instantiates it and muxes the result with the FSM.

Test Plan:
- Reset asserted mid-EXC_WAIT -> exc_req=0, status_q=0, state RUN immediately, without waiting for a clock edge.
- stswrite with status_in=3'b100, then bz next cycle with pc=0x100, imm=3 -> take=1, next_pc=0x110. bnz in the same setup -> next_pc=0x104.
- BYPASS=0: stswrite status_in=3'b010 and bn in the same cycle, with status_q=0 -> take=0. Same stimulus with BYPASS=1 -> take=1.
- jal at pc=0x0040_0000, jtarget=0x10 -> next_pc=0x0000_0040, link_we=1, link_data=0x0040_0004. jr with rs_val=0xFFFF_FFFC -> next_pc=0xFFFF_FFFC.
- Branch wrap: pc=0xFFFF_FFF8, imm=1, bv with f[0]=1 -> next_pc=0x0000_0000.
- TRAP_EN=1: stswrite with status_in=3'b001 at pc=0x200 -> next cycle exc_req=1, stall=1, epc=0x200. Hold for 5 cycles, then exc_ack -> one cycle with next_pc=0x80, then RUN, and ovf_sticky stays 1.
